// File: rtl/mem_arb_if.sv
// Bundle of the data-port, fetch-port and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_arb_if;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;

  logic        f_req_i;
  logic [31:0] f_addr_i;
  logic [31:0] f_rdata_o;
  logic        f_ack_o;

  logic        m_req_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_rdata_i;
  logic        m_ack_i;

  logic        hold_flag_o;
  logic        err_o;

  modport slave (
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    output d_rdata_o, d_ack_o,
    input  f_req_i, f_addr_i,
    output f_rdata_o, f_ack_o,
    output m_req_o, m_we_o, m_addr_o, m_wdata_o, m_be_o,
    input  m_rdata_i, m_ack_i,
    output hold_flag_o, err_o
  );

  modport master (
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    input  d_rdata_o, d_ack_o,
    output f_req_i, f_addr_i,
    input  f_rdata_o, f_ack_o,
    input  m_req_o, m_we_o, m_addr_o, m_wdata_o, m_be_o,
    output m_rdata_i, m_ack_i,
    input  hold_flag_o, err_o
  );
endinterface

// File: rtl/mem_arb.sv
// Single-outstanding arbiter of data and fetch ports onto one memory bus, with fetch anti-starvation and timeout.
// Latency: grant->m_req 1 cycle, m_ack->x_ack 1 cycle; requesters are stalled via hold_flag_o until their ack.
module mem_arb #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_F} state_t;

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t        state_q, state_d;
  logic [2:0]    starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_exp;
  logic          busy;
  logic          grant_d, grant_f;
  logic          done, abort;

  // The abort edge is the one on which the counter would reach TIMEOUT-1.
  assign tmo_exp = (tmo_cnt == TW'(TIMEOUT - 2));
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.d_req_i && !(bus.f_req_i && starve_cnt == 3'(STARVE_MAX)))
          state_d = BUSY_D;
        else if (bus.f_req_i)
          state_d = BUSY_F;
      end
      BUSY_D, BUSY_F: begin
        if (bus.m_ack_i || tmo_exp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = (state_d == BUSY_D);
        grant_f = (state_d == BUSY_F);
      end
      BUSY_D, BUSY_F: begin
        done  = bus.m_ack_i;
        abort = !bus.m_ack_i && tmo_exp;
      end
      default: ;
    endcase
  end

  assign bus.hold_flag_o = (bus.f_req_i & ~bus.f_ack_o) | (bus.d_req_i & ~bus.d_ack_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_req_o   <= 1'b0;
      bus.m_we_o    <= 1'b0;
      bus.m_addr_o  <= '0;
      bus.m_wdata_o <= '0;
      bus.m_be_o    <= '0;
      bus.d_rdata_o <= '0;
      bus.d_ack_o   <= 1'b0;
      bus.f_rdata_o <= '0;
      bus.f_ack_o   <= 1'b0;
      bus.err_o     <= 1'b0;
      starve_cnt    <= '0;
      tmo_cnt       <= '0;
    end else begin
      bus.d_ack_o <= 1'b0;
      bus.f_ack_o <= 1'b0;
      bus.err_o   <= abort;

      if (grant_d) begin
        bus.m_req_o   <= 1'b1;
        bus.m_we_o    <= bus.d_we_i;
        bus.m_addr_o  <= bus.d_addr_i;
        bus.m_wdata_o <= bus.d_wdata_i;
        bus.m_be_o    <= bus.d_be_i;
      end else if (grant_f) begin
        bus.m_req_o   <= 1'b1;
        bus.m_we_o    <= 1'b0;
        bus.m_addr_o  <= bus.f_addr_i;
        bus.m_wdata_o <= '0;
        bus.m_be_o    <= 4'hF;
      end else if (done || abort) begin
        bus.m_req_o   <= 1'b0;
      end

      if (grant_d || grant_f)           tmo_cnt <= '0;
      else if (busy && !bus.m_ack_i)    tmo_cnt <= tmo_cnt + 1'b1;

      if (grant_f)
        starve_cnt <= '0;
      else if (grant_d && !bus.f_req_i)
        starve_cnt <= '0;
      else if (grant_d && starve_cnt != 3'd7)
        starve_cnt <= starve_cnt + 3'd1;

      // An aborted transaction returns zero data instead of whatever is on the bus.
      if ((done || abort) && state_q == BUSY_D) begin
        bus.d_ack_o   <= 1'b1;
        bus.d_rdata_o <= done ? bus.m_rdata_i : '0;
      end
      if ((done || abort) && state_q == BUSY_F) begin
        bus.f_ack_o   <= 1'b1;
        bus.f_rdata_o <= done ? bus.m_rdata_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: expected grants and acks are queued by the stimulus and
// checked by a memory responder and an ack monitor.
module tb_mem_arb;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } grant_t;

  typedef struct packed {
    logic        f;
    logic        err;
    logic [31:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int tests = 0;
  int failed = 0;

  grant_t grant_q[$];
  ack_t   ack_q[$];

  logic        mem_ack = 1'b0;
  logic        late_ack = 1'b0;
  logic [31:0] mem_rd = '0;
  int          mem_lat = 1;
  bit          mem_en = 1'b1;

  mem_arb_if bus ();

  assign bus.m_ack_i   = mem_ack | late_ack;
  assign bus.m_rdata_i = mem_rd;

  mem_arb #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic push_grant(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
    grant_t g;
    g.we = we; g.addr = addr; g.be = be; g.wdata = wdata;
    grant_q.push_back(g);
  endtask

  task automatic push_ack(input logic f, input logic err, input logic [31:0] rdata);
    ack_t a;
    a.f = f; a.err = err; a.rdata = rdata;
    ack_q.push_back(a);
  endtask

  // Memory model: checks each new request against the expected grant, checks that
  // the request stays stable, and acks mem_lat cycles after m_req_o rises.
  bit     m_busy = 1'b0;
  bit     m_unstable = 1'b0;
  int     m_cnt = 0;
  grant_t m_snap;

  always @(negedge clk) begin
    grant_t cur;
    grant_t g;
    mem_ack = 1'b0;
    cur = {bus.m_we_o, bus.m_addr_o, bus.m_be_o, bus.m_wdata_o};
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (bus.m_req_o && !m_busy) begin
      m_busy = 1'b1;
      m_cnt = 0;
      m_unstable = 1'b0;
      m_snap = cur;
      if (grant_q.size() == 0) begin
        tests++; failed++;
        $display("FAIL grant_unexpected: got addr 0x%0h with no grant expected", bus.m_addr_o);
      end else begin
        g = grant_q.pop_front();
        check("grant_we", 64'(bus.m_we_o), 64'(g.we));
        check("grant_addr", 64'(bus.m_addr_o), 64'(g.addr));
        check("grant_be", 64'(bus.m_be_o), 64'(g.be));
        if (g.we) check("grant_wdata", 64'(bus.m_wdata_o), 64'(g.wdata));
      end
    end else if (m_busy && !bus.m_req_o) begin
      m_busy = 1'b0;
    end
    if (m_busy) begin
      if (cur != m_snap) m_unstable = 1'b1;
      if (m_cnt == mem_lat && mem_en) begin
        mem_ack = 1'b1;
        mem_rd  = rdata_for(bus.m_addr_o);
        check("m_stable", 64'(m_unstable), 64'd0);
      end
      m_cnt++;
    end
  end

  // Ack monitor: every ack/err pulse must match the oldest expected completion.
  always @(negedge clk) begin
    ack_t a;
    ack_t act;
    if (rst_n && (bus.d_ack_o || bus.f_ack_o || bus.err_o)) begin
      check("ack_exclusive", 64'(bus.d_ack_o & bus.f_ack_o), 64'd0);
      act.f = bus.f_ack_o;
      act.err = bus.err_o;
      act.rdata = bus.f_ack_o ? bus.f_rdata_o : bus.d_rdata_o;
      if (ack_q.size() == 0) begin
        tests++; failed++;
        $display("FAIL ack_unexpected: got f=%0b d=%0b err=%0b with none expected",
                 bus.f_ack_o, bus.d_ack_o, bus.err_o);
      end else begin
        a = ack_q.pop_front();
        check("ack_src_err_rdata", 64'(act), 64'(a));
      end
    end
  end

  task automatic wait_ack(input bit want_f, input int bound, output int cyc);
    logic seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < bound) begin
      @(negedge clk);
      cyc++;
      seen = want_f ? bus.f_ack_o : bus.d_ack_o;
    end
    check(want_f ? "f_ack_seen" : "d_ack_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   d_seen;
    int   d_before;
    int   d_after;
    int   hi;
    bit   f_done;

    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_be_i = '0;
    bus.f_req_i = 0; bus.f_addr_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_bus", {31'd0, bus.m_req_o, bus.m_we_o, bus.m_be_o, bus.m_addr_o[26:0]}, 64'd0);
    check("rst_m_wdata", 64'(bus.m_wdata_o), 64'd0);
    check("rst_rdata", {bus.d_rdata_o, bus.f_rdata_o}, 64'd0);
    check("rst_pulses", {61'd0, bus.d_ack_o, bus.f_ack_o, bus.err_o}, 64'd0);
    check("rst_hold", 64'(bus.hold_flag_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch only, memory acks 3 cycles after m_req_o
    mem_lat = 3;
    push_grant(1'b0, 32'h100, 4'hF, 32'h0);
    push_ack(1'b1, 1'b0, 32'h13);
    bus.f_addr_i = 32'h100;
    bus.f_req_i = 1'b1;
    @(negedge clk);
    check("t1_mreq_next_cycle", 64'(bus.m_req_o), 64'd1);
    check("t1_hold_pending", 64'(bus.hold_flag_o), 64'd1);
    wait_ack(1'b1, 40, cyc);
    check("t1_ack_latency", 64'(cyc), 64'd4);
    check("t1_hold_at_ack", 64'(bus.hold_flag_o), 64'd0);
    check("t1_f_rdata", 64'(bus.f_rdata_o), 64'h13);
    check("t1_d_rdata", 64'(bus.d_rdata_o), 64'd0);
    bus.f_req_i = 1'b0;
    @(negedge clk);

    // Stray m_ack_i in IDLE
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_mreq", 64'(bus.m_req_o), 64'd0);
    check("idle_ack_f_rdata", 64'(bus.f_rdata_o), 64'h13);

    // Simultaneous write + fetch: data first
    mem_lat = 1;
    push_grant(1'b1, 32'h2004, 4'h3, 32'hDEADBEEF);
    push_grant(1'b0, 32'h200, 4'hF, 32'h0);
    push_ack(1'b0, 1'b0, 32'hC0DE2004);
    push_ack(1'b1, 1'b0, 32'hC0DE0200);
    bus.d_we_i = 1'b1; bus.d_addr_i = 32'h2004; bus.d_wdata_i = 32'hDEADBEEF; bus.d_be_i = 4'h3;
    bus.f_addr_i = 32'h200;
    bus.d_req_i = 1'b1;
    bus.f_req_i = 1'b1;
    cyc = 0;
    d_seen = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.f_ack_o) check("t2_hold_high", 64'(bus.hold_flag_o), 64'd1);
      if (bus.d_ack_o) begin
        d_seen = cyc;
        bus.d_req_i = 1'b0;
      end
    end while (!bus.f_ack_o && cyc < 40);
    check("t2_f_ack", 64'(bus.f_ack_o), 64'd1);
    check("t2_d_ack_cycle", 64'(d_seen), 64'd3);
    check("t2_f_ack_cycle", 64'(cyc), 64'd6);
    check("t2_hold_at_f_ack", 64'(bus.hold_flag_o), 64'd0);
    check("t2_d_rdata", 64'(bus.d_rdata_o), 64'hC0DE2004);
    bus.f_req_i = 1'b0;
    @(negedge clk);

    // Starvation: 4 data grants, one fetch, then data again
    bus.d_we_i = 1'b0; bus.d_addr_i = 32'h3000; bus.d_wdata_i = 32'h0; bus.d_be_i = 4'hF;
    bus.f_addr_i = 32'h400;
    for (int i = 0; i < 4; i++) begin
      push_grant(1'b0, 32'h3000, 4'hF, 32'h0);
      push_ack(1'b0, 1'b0, 32'hC0DE3000);
    end
    push_grant(1'b0, 32'h400, 4'hF, 32'h0);
    push_ack(1'b1, 1'b0, 32'hC0DE0400);
    push_grant(1'b0, 32'h3000, 4'hF, 32'h0);
    push_ack(1'b0, 1'b0, 32'hC0DE3000);
    bus.d_req_i = 1'b1;
    bus.f_req_i = 1'b1;
    cyc = 0; d_before = 0; d_after = 0; f_done = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.f_ack_o) begin
        f_done = 1'b1;
        bus.f_req_i = 1'b0;
      end
      if (bus.d_ack_o) begin
        if (f_done) begin
          d_after++;
          bus.d_req_i = 1'b0;
        end else begin
          d_before++;
        end
      end
    end while (!(f_done && d_after > 0) && cyc < 80);
    check("t3_data_before_fetch", 64'(d_before), 64'd4);
    check("t3_data_after_fetch", 64'(d_after), 64'd1);
    bus.d_req_i = 1'b0;
    bus.f_req_i = 1'b0;
    @(negedge clk);

    // Timeout: data read with no memory ack
    mem_en = 1'b0;
    bus.d_we_i = 1'b0; bus.d_addr_i = 32'h5000; bus.d_be_i = 4'hF;
    push_grant(1'b0, 32'h5000, 4'hF, 32'h0);
    push_ack(1'b0, 1'b1, 32'h0);
    bus.d_req_i = 1'b1;
    cyc = 0;
    hi = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.m_req_o) hi++;
    end while (!bus.d_ack_o && cyc < 60);
    check("t4_d_ack", 64'(bus.d_ack_o), 64'd1);
    check("t4_err_with_ack", 64'(bus.err_o), 64'd1);
    check("t4_mreq_cycles", 64'(hi), 64'd15);
    check("t4_mreq_low", 64'(bus.m_req_o), 64'd0);
    bus.d_req_i = 1'b0;
    mem_en = 1'b1;
    @(negedge clk);
    check("t4_err_one_pulse", 64'(bus.err_o), 64'd0);

    // Next request after the abort is served normally
    mem_lat = 2;
    bus.d_we_i = 1'b1; bus.d_addr_i = 32'h5008; bus.d_wdata_i = 32'h12345678; bus.d_be_i = 4'hC;
    push_grant(1'b1, 32'h5008, 4'hC, 32'h12345678);
    push_ack(1'b0, 1'b0, 32'hC0DE5008);
    bus.d_req_i = 1'b1;
    wait_ack(1'b0, 40, cyc);
    check("t4_next_rdata", 64'(bus.d_rdata_o), 64'hC0DE5008);
    bus.d_req_i = 1'b0;
    @(negedge clk);

    // Reset in the middle of a fetch
    mem_en = 1'b0;
    bus.f_addr_i = 32'h600;
    push_grant(1'b0, 32'h600, 4'hF, 32'h0);
    bus.f_req_i = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_busy_before_reset", 64'(bus.m_req_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_m_ctrl", {59'd0, bus.m_req_o, bus.m_be_o}, 64'd0);
    check("t5_rst_m_addr", {bus.m_addr_o, bus.m_wdata_o}, 64'd0);
    check("t5_rst_we", 64'(bus.m_we_o), 64'd0);
    check("t5_rst_rdata", {bus.d_rdata_o, bus.f_rdata_o}, 64'd0);
    check("t5_rst_pulses", {61'd0, bus.d_ack_o, bus.f_ack_o, bus.err_o}, 64'd0);
    @(negedge clk);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    check("t5_no_ack_in_reset", {62'd0, bus.f_ack_o, bus.m_req_o}, 64'd0);
    mem_en = 1'b1;
    mem_lat = 2;
    push_grant(1'b0, 32'h600, 4'hF, 32'h0);
    push_ack(1'b1, 1'b0, 32'hC0DE0600);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_regrant_after_reset", 64'(bus.m_req_o), 64'd1);
    wait_ack(1'b1, 40, cyc);
    check("t5_f_rdata", 64'(bus.f_rdata_o), 64'hC0DE0600);
    bus.f_req_i = 1'b0;

    repeat (4) @(negedge clk);
    check("end_grant_queue_empty", 64'(grant_q.size()), 64'd0);
    check("end_ack_queue_empty", 64'(ack_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: STARVE_MAX, 4, consecutive data grants allowed while a fetch waits; after that the fetch is granted once.
REQ-002 Parameter: TIMEOUT, 16, cycles allowed for m_ack_i before a transaction is aborted.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 d_req_i  input  1  data requester (MEM stage) access request.
REQ-007 d_we_i  input  1  data write enable; 0 means read.
REQ-008 d_addr_i  input  32  data byte address.
REQ-009 d_wdata_i  input  32  data write word.
REQ-010 d_be_i  input  4  data byte enables.
REQ-011 d_rdata_o  output  32  data read word, registered.
REQ-012 d_ack_o  output  1  data transaction done, one-cycle pulse.
REQ-013 f_req_i  input  1  instruction fetch request; always a read.
REQ-014 f_addr_i  input  32  fetch address.
REQ-015 f_rdata_o  output  32  fetched instruction, registered.
REQ-016 f_ack_o  output  1  fetch done, one-cycle pulse.
REQ-017 m_req_o, m_we_o  output  1 each  memory request and write enable.
REQ-018 m_addr_o, m_wdata_o  output  32 each  memory address and write data.
REQ-019 m_be_o  output  4  memory byte enables; 4'b1111 for fetches.
REQ-020 m_rdata_i  input  32  memory read data, valid with m_ack_i.
REQ-021 m_ack_i  input  1  memory completion, one-cycle pulse.
REQ-022 hold_flag_o  output  1  stall request to ctrl.
REQ-023 err_o  output  1  timeout abort, one-cycle pulse.

Function
REQ-024 FSM states: IDLE, BUSY_D, BUSY_F; one transaction is outstanding at most.
REQ-025 Arbitration in IDLE:
- Only d_req_i high: go to BUSY_D.
- Only f_req_i high: go to BUSY_F.
- Both high: go to BUSY_D unless starve_cnt == STARVE_MAX, in which case go to BUSY_F.
- Neither high: stay in IDLE.
REQ-026 Grant latches the winner's we, addr, wdata and be into registers; m_* outputs are driven only from these registers.
REQ-027 m_req_o goes high the cycle after the grant and stays high through the cycle m_ack_i is sampled high.
REQ-028 m_* outputs are held stable while m_req_o is high.
REQ-029 On m_ack_i in BUSY_x:
- Register m_rdata_i into x_rdata_o; write transactions still update it.
- Pulse x_ack_o in the next cycle.
- Drop m_req_o in that same next cycle.
- Return to IDLE.
REQ-030 Latency: request sampled in cycle N, m_req_o in N+1, m_ack_i in cycle M, x_ack_o in M+1; next grant no earlier than M+1 and next m_req_o no earlier than M+2.
REQ-031 x_rdata_o holds its value until the next completion for that requester.
REQ-032 Requesters hold req and fields until their ack; a deasserted req during BUSY is ignored and the transaction completes.
REQ-033 m_ack_i while in IDLE is ignored.
REQ-034 starve_cnt, 3 bits, saturating:
- Increments on a data grant made while f_req_i is high.
- Clears on a fetch grant.
- Clears on a data grant made while f_req_i is low.
REQ-035 Timeout:
- tmo_cnt clears on grant and increments each BUSY cycle without m_ack_i.
- At TIMEOUT-1: m_req_o drops, err_o pulses, x_ack_o pulses with x_rdata_o = 0, FSM returns to IDLE.
REQ-036 hold_flag_o = (f_req_i & ~f_ack_o) | (d_req_i & ~d_ack_o), combinational.

Reset
REQ-037 rst_n low asynchronously forces:
- FSM to IDLE; starve_cnt and tmo_cnt to 0.
- All registered outputs (m_*, x_rdata_o, x_ack_o, err_o) to 0.
REQ-038 Reset mid-transaction abandons it with no ack pulse; the first grant is evaluated on the first rising edge after rst_n rises.

Verification
REQ-039 Fetch only: f_req_i=1, f_addr_i=0x100, m_ack_i 3 cycles after m_req_o with m_rdata_i=0x00000013 -> m_addr_o=0x100, m_be_o=4'hF, f_rdata_o=0x13, f_ack_o one pulse, d_ack_o never.
REQ-040 Simultaneous requests: d_req_i and f_req_i rise together, d_we_i=1, d_addr_i=0x2004, d_wdata_i=0xDEADBEEF, d_be_i=4'h3 -> data served first with m_we_o=1 and m_be_o=4'h3, fetch served next, hold_flag_o high until f_ack_o.
REQ-041 Starvation: f_req_i held high with d_req_i continuously high and every memory ack after 1 cycle -> exactly 4 data grants, then one fetch grant, then data again.
REQ-042 Timeout: data read granted, m_ack_i held low -> m_req_o drops after 15 BUSY cycles, err_o and d_ack_o pulse together, d_rdata_o=0, next request accepted.
REQ-043 Reset mid-transaction: rst_n low while in BUSY_F -> all outputs 0 immediately, no f_ack_o pulse, late m_ack_i ignored, fetch re-granted after rst_n rises.
